vec_dot_accumulator: RTL and testbench

//  Downstream stage of the element-wise vector multiplier. Each beat, it takes one
//  VEC_LEN-element signed product vector and reduces it with an adder tree.
//  It accumulates NUM_BEATS such beats, i.e. one matrix row segment (5x400 shape by

---
 rtl/vec_dot_accumulator.sv | 134 +++++++++++++
 tb/tb_vec_dot_accumulator.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/vec_dot_accumulator.sv
// rtl/vec_dot_accumulator.sv - adder-tree reduction of product beats, accumulated into one signed dot-product per row
// Optional macro VEC_DOT_ACC_SAT_EN: saturating accumulate with sticky sat_flag_o; undefined means wrap and sat_flag_o=0.
module vec_dot_accumulator #(
  parameter int VEC_LEN   = 5,
  parameter int DATA_W    = 32,
  parameter int NUM_BEATS = 400,
  parameter int ACC_W     = 48
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           clr_i,
  input  logic                           in_valid_i,
  output logic                           in_ready_o,
  input  logic [VEC_LEN*DATA_W-1:0]      in_data_i,
  output logic                           out_valid_o,
  input  logic                           out_ready_i,
  output logic [ACC_W-1:0]               out_data_o,
  output logic [$clog2(NUM_BEATS+1)-1:0] beat_cnt_o,
  output logic                           sat_flag_o
);
  localparam int CNT_W = $clog2(NUM_BEATS+1);
`ifdef VEC_DOT_ACC_SAT_EN
  // Wide enough that acc plus a full tree sum never wraps before the clamp decision.
  localparam int SUM_W = ((ACC_W > DATA_W) ? ACC_W : DATA_W) + $clog2(VEC_LEN) + 2;
`else
  localparam int SUM_W = ACC_W;
`endif

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;

  state_t                   state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d, acc_next;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic signed [DATA_W-1:0] elem;
  logic signed [SUM_W-1:0]  tree_sum, sum_ext;
  logic                     accept, take;

  assign in_ready_o  = (state_q != S_DONE);
  assign out_valid_o = (state_q == S_DONE);
  assign out_data_o  = acc_q;
  assign beat_cnt_o  = cnt_q;
  assign accept      = in_valid_i && in_ready_o && !clr_i;
  assign take        = out_valid_o && out_ready_i && !clr_i;

  always_comb begin
    elem     = '0;
    tree_sum = '0;
    for (int i = 0; i < VEC_LEN; i++) begin
      elem     = in_data_i[i*DATA_W +: DATA_W];
      tree_sum = tree_sum + SUM_W'(elem);
    end
    sum_ext = SUM_W'(acc_q) + tree_sum;
  end

`ifdef VEC_DOT_ACC_SAT_EN
  localparam logic signed [SUM_W-1:0] SAT_MAX = {{(SUM_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SAT_MIN = ~SAT_MAX;

  logic clamp;
  logic sat_q, sat_d;

  always_comb begin
    clamp    = 1'b0;
    acc_next = sum_ext[ACC_W-1:0];
    if (sum_ext > SAT_MAX) begin
      clamp    = 1'b1;
      acc_next = SAT_MAX[ACC_W-1:0];
    end else if (sum_ext < SAT_MIN) begin
      clamp    = 1'b1;
      acc_next = SAT_MIN[ACC_W-1:0];
    end
  end

  always_comb begin
    sat_d = sat_q;
    if (clr_i || take)
      sat_d = 1'b0;
    else if (accept && clamp)
      sat_d = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) sat_q <= 1'b0;
    else       sat_q <= sat_d;
  end

  assign sat_flag_o = sat_q;
`else
  assign acc_next   = sum_ext;
  assign sat_flag_o = 1'b0;
`endif

  // clr wins over both handshakes; a beat offered in that cycle is dropped.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    if (clr_i) begin
      state_d = S_IDLE;
      acc_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE, S_ACCUM: begin
          if (in_valid_i) begin
            acc_d   = acc_next;
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = (cnt_q == CNT_W'(NUM_BEATS-1)) ? S_DONE : S_ACCUM;
          end
        end
        S_DONE: begin
          if (out_ready_i) begin
            acc_d   = '0;
            cnt_d   = '0;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_vec_dot_accumulator.sv
// tb/tb_vec_dot_accumulator.sv - bench for vec_dot_accumulator: 40-bit and 34-bit accumulators driven in lockstep
module tb_vec_dot_accumulator;
  localparam int VL   = 5;
  localparam int DW   = 32;
  localparam int NB   = 4;
  localparam int AW_A = 40;
  localparam int AW_B = 34;
`ifdef VEC_DOT_ACC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [VL*DW-1:0] in_data;
  logic rdy_a, rdy_b, ov_a, ov_b, sat_a, sat_b;
  logic [AW_A-1:0] od_a;
  logic [AW_B-1:0] od_b;
  logic [2:0] cnt_a, cnt_b;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  vec_dot_accumulator #(.VEC_LEN(VL), .DATA_W(DW), .NUM_BEATS(NB), .ACC_W(AW_A)) u_a (
    .clk_i(clk), .rst_i(rst), .clr_i(clr), .in_valid_i(in_valid), .in_ready_o(rdy_a),
    .in_data_i(in_data), .out_valid_o(ov_a), .out_ready_i(out_ready), .out_data_o(od_a),
    .beat_cnt_o(cnt_a), .sat_flag_o(sat_a));

  vec_dot_accumulator #(.VEC_LEN(VL), .DATA_W(DW), .NUM_BEATS(NB), .ACC_W(AW_B)) u_b (
    .clk_i(clk), .rst_i(rst), .clr_i(clr), .in_valid_i(in_valid), .in_ready_o(rdy_b),
    .in_data_i(in_data), .out_valid_o(ov_b), .out_ready_i(out_ready), .out_data_o(od_b),
    .beat_cnt_o(cnt_b), .sat_flag_o(sat_b));

  typedef struct {
    logic [VL*DW-1:0] d;
    longint           exp_a;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  function automatic logic [VL*DW-1:0] pack5(input int a, input int b, input int c, input int d, input int e);
    return {e, d, c, b, a};
  endfunction

  function automatic longint tree_of(input logic [VL*DW-1:0] d);
    longint s = 0;
    for (int i = 0; i < VL; i++) s += longint'($signed(d[i*DW +: DW]));
    return s;
  endfunction

  // Result of one accumulate in a w-bit accumulator: clamp when saturating, else two's complement wrap.
  function automatic longint model_step(input longint acc, input longint t, input int w, inout bit f);
    longint s  = acc + t;
    longint hi = (longint'(1) <<< (w-1)) - 1;
    if (SAT) begin
      if (s > hi) begin
        s = hi;
        f = 1'b1;
      end else if (s < -hi - 1) begin
        s = -hi - 1;
        f = 1'b1;
      end
    end else begin
      s = (s <<< (64 - w)) >>> (64 - w);
    end
    return s;
  endfunction

  task automatic drive_beat(input logic [VL*DW-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 'x;
  endtask

  task automatic finish_row(input longint ea, input bit fa, input longint eb, input bit fb,
                            input int hold, input string nm);
    chk({nm, "_ov"},   64'(ov_a), 1);
    chk({nm, "_ovb"},  64'(ov_b), 1);
    chk({nm, "_cnt"},  64'(cnt_a), NB);
    chk({nm, "_rdy"},  64'(rdy_a), 0);
    chk({nm, "_da"},   64'($signed(od_a)), ea);
    chk({nm, "_sa"},   64'(sat_a), 64'(fa));
    chk({nm, "_db"},   64'($signed(od_b)), eb);
    chk({nm, "_sb"},   64'(sat_b), 64'(fb));
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      in_data  = pack5(int'($urandom), 1, 2, 3, 4);
      @(negedge clk);
      chk({nm, "_hold_ov"},  64'(ov_a), 1);
      chk({nm, "_hold_rdy"}, 64'(rdy_a), 0);
      chk({nm, "_hold_da"},  64'($signed(od_a)), ea);
    end
    in_valid  = 1'b0;
    in_data   = 'x;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({nm, "_taken_ov"},  64'(ov_a), 0);
    chk({nm, "_taken_cnt"}, 64'(cnt_b), 0);
    chk({nm, "_taken_da"},  64'($signed(od_a)), 0);
    chk({nm, "_taken_sb"},  64'(sat_b), 0);
    chk({nm, "_taken_rdy"}, 64'(rdy_a), 1);
  endtask

  task automatic run_row(input logic [VL*DW-1:0] d, input longint ea, input int hold, input string nm);
    longint eb = 0;
    bit     fb = 1'b0;
    longint t  = tree_of(d);
    for (int b = 0; b < NB; b++) begin
      chk({nm, "_inrdy"}, 64'(rdy_b), 1);
      eb = model_step(eb, t, AW_B, fb);
      drive_beat(d);
      if (b == NB - 2) chk({nm, "_early_ov"}, 64'(ov_a), 0);
    end
    finish_row(ea, 1'b0, eb, fb, hold, nm);
  endtask

  task automatic rand_row(input int r);
    longint ea = 0, eb = 0, t;
    bit fa = 1'b0, fb = 1'b0;
    int got = 0;
    logic [VL*DW-1:0] d;
    while (got < NB) begin
      if ($urandom_range(0, 3) != 0) begin
        for (int e = 0; e < VL; e++)
          d[e*DW +: DW] = ($urandom_range(0, 1) != 0) ? int'($urandom) : int'($urandom_range(0, 200)) - 100;
        t  = tree_of(d);
        ea = model_step(ea, t, AW_A, fa);
        eb = model_step(eb, t, AW_B, fb);
        got++;
        drive_beat(d);
      end else begin
        @(negedge clk);
      end
    end
    finish_row(ea, fa, eb, fb, int'($urandom_range(0, 3)), $sformatf("rnd%0d", r));
  endtask

  initial begin
    in_data = 'x;
    tbl[0] = '{pack5(3, 3, 3, 3, 3), 60};
    tbl[1] = '{pack5(-7, 2, 2, 2, 0), -4};
    tbl[2] = '{pack5(-1, -1, -1, -1, -1), -20};
    tbl[3] = '{pack5(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF), 64'sd42949672940};
    tbl[4] = '{pack5(32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000), -64'sd42949672960};
    tbl[5] = '{pack5(100, -50, 25, -12, 6), 276};

    #1;
    chk("rst_rdy", 64'(rdy_a), 1);
    chk("rst_ov",  64'(ov_a), 0);
    chk("rst_da",  64'($signed(od_a)), 0);
    chk("rst_cnt", 64'(cnt_a), 0);
    chk("rst_sat", 64'(sat_b), 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 6; i++)
      run_row(tbl[i].d, tbl[i].exp_a, 0, $sformatf("tbl%0d", i));

    // 34-bit overflow row: wrapped value, or clamp to 2^33-1 with sticky flag.
    drive_beat(tbl[3].d);
    drive_beat(tbl[3].d);
    drive_beat(tbl[3].d);
    drive_beat(tbl[3].d);
    chk("ovf_db", 64'($signed(od_b)), SAT ? 64'sd8589934591 : 64'sd8589934572);
    chk("ovf_sb", 64'(sat_b), 64'(SAT));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Backpressure: ten stalled cycles with in_valid held high.
    run_row(tbl[0].d, 60, 10, "bp");

    // clr after two beats drops the partial sum and the beat offered alongside it.
    drive_beat(pack5(1, 1, 1, 1, 1));
    drive_beat(pack5(1, 1, 1, 1, 1));
    clr      = 1'b1;
    in_valid = 1'b1;
    in_data  = pack5(1, 1, 1, 1, 1);
    @(negedge clk);
    clr      = 1'b0;
    in_valid = 1'b0;
    in_data  = 'x;
    chk("clr_cnt", 64'(cnt_a), 0);
    chk("clr_da",  64'($signed(od_a)), 0);
    chk("clr_ov",  64'(ov_a), 0);
    run_row(pack5(1, 1, 1, 1, 1), 20, 0, "after_clr");

    // Asynchronous reset mid-row and in DONE, observed before the next clock edge.
    drive_beat(pack5(5, 5, 5, 5, 5));
    drive_beat(pack5(5, 5, 5, 5, 5));
    #2 rst = 1'b1;
    #1;
    chk("arst_mid_cnt", 64'(cnt_a), 0);
    chk("arst_mid_da",  64'($signed(od_a)), 0);
    @(negedge clk);
    rst = 1'b0;
    for (int b = 0; b < NB; b++) drive_beat(pack5(5, 5, 5, 5, 5));
    chk("pre_arst_ov", 64'(ov_a), 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_done_ov",  64'(ov_a), 0);
    chk("arst_done_cnt", 64'(cnt_a), 0);
    @(negedge clk);
    rst = 1'b0;
    run_row(pack5(2, 2, 2, 2, 2), 40, 0, "after_rst");

    for (int r = 0; r < 40; r++) rand_row(r);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
